queue1in4: RTL

QUEUE1IN4 -- requirements
Module: queue1in4

---
 rtl/queue1in4_if.sv | 30 +++
 rtl/queue1in4.sv | 97 +++++++++
 2 files changed

// File: rtl/queue1in4_if.sv
// rtl/queue1in4_if.sv - rename-to-issue group buffer handshake bundle
interface queue1in4_if #(
  parameter int WIDTH_REG = 3,
  parameter int WIDTH_TAG = 3,
  parameter int WIDTH_BRM = 3
);
  localparam int WIDTH = 7 + WIDTH_BRM + WIDTH_TAG + 3 * WIDTH_REG + 3;

  logic [WIDTH-1:0]       i_inst;
  logic                   i_valid;
  logic                   o_ready;
  logic [WIDTH-1:0]       o_inst1;
  logic [WIDTH-1:0]       o_inst2;
  logic [WIDTH-1:0]       o_inst3;
  logic [WIDTH-1:0]       o_inst4;
  logic                   o_en;
  logic                   i_ready;
  logic [4*WIDTH_REG-1:0] i_wdest4x;
  logic [WIDTH_BRM-1:0]   i_BrKill;

  modport master (
    output i_inst, i_valid, i_ready, i_wdest4x, i_BrKill,
    input  o_ready, o_inst1, o_inst2, o_inst3, o_inst4, o_en
  );

  modport slave (
    input  i_inst, i_valid, i_ready, i_wdest4x, i_BrKill,
    output o_ready, o_inst1, o_inst2, o_inst3, o_inst4, o_en
  );
endinterface

// File: rtl/queue1in4.sv
// rtl/queue1in4.sv - 8-entry buffer that forwards renamed instructions in groups of up to 4
module queue1in4 #(
  parameter int WIDTH_REG = 3,
  parameter int WIDTH_TAG = 3,
  parameter int WIDTH_BRM = 3,
  parameter int TIMEOUT   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  queue1in4_if.slave bus
);
  localparam int WIDTH   = 7 + WIDTH_BRM + WIDTH_TAG + 3 * WIDTH_REG + 3;
  localparam int DEPTH   = 8;
  localparam int PR1_LSB = 3;
  localparam int PR2_LSB = 3 + WIDTH_REG;
  localparam int BRM_LSB = 3 + 3 * WIDTH_REG + WIDTH_TAG;
  localparam int TW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [2:0]       head_q, head_d;
  logic [2:0]       tail_q, tail_d;
  logic [3:0]       count_q, count_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             en, ready, push, pop;
  logic [2:0]       pop_n;
  logic [2:0]       idx;
  logic [WIDTH-1:0] lane [4];

  // Kill clears val; wakeup sets p1/p2 on a match with any nonzero destination.
  function automatic logic [WIDTH-1:0] refresh(input logic [WIDTH-1:0]       e,
                                               input logic [4*WIDTH_REG-1:0] wdest,
                                               input logic [WIDTH_BRM-1:0]   kill);
    logic [WIDTH-1:0]     r;
    logic [WIDTH_REG-1:0] w;
    r = e;
    if ((e[BRM_LSB +: WIDTH_BRM] & kill) != '0) r[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w = wdest[k*WIDTH_REG +: WIDTH_REG];
      if (w != '0) begin
        if (e[PR1_LSB +: WIDTH_REG] == w) r[0] = 1'b1;
        if (e[PR2_LSB +: WIDTH_REG] == w) r[1] = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    en    = (count_q >= 4'd4) || ((count_q != 4'd0) && (timer_q == TIMEOUT_T));
    ready = (count_q != 4'd8);
    push  = bus.i_valid && ready;
    pop   = en && bus.i_ready;
    pop_n = (count_q > 4'd4) ? 3'd4 : count_q[2:0];
    idx   = head_q;
    for (int k = 0; k < 4; k++) begin
      idx     = head_q + 3'(k);
      lane[k] = (4'(k) < count_q) ? mem_q[idx] : '0;
    end
  end

  assign bus.o_en    = en;
  assign bus.o_ready = ready;
  assign bus.o_inst1 = lane[0];
  assign bus.o_inst2 = lane[1];
  assign bus.o_inst3 = lane[2];
  assign bus.o_inst4 = lane[3];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = refresh(mem_q[i], bus.i_wdest4x, bus.i_BrKill);
    if (push) mem_d[tail_q] = refresh(bus.i_inst, bus.i_wdest4x, bus.i_BrKill);
    head_d  = pop ? head_q + pop_n : head_q;
    tail_d  = push ? tail_q + 3'd1 : tail_q;
    count_d = count_q - (pop ? {1'b0, pop_n} : 4'd0) + (push ? 4'd1 : 4'd0);
    // A group waits for a full lane set unless the buffer idles long enough.
    if ((count_q == 4'd0) || push || pop) timer_d = '0;
    else if (timer_q != TIMEOUT_T)        timer_d = timer_q + 1'b1;
    else                                  timer_d = timer_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      timer_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      timer_q <= timer_d;
    end
  end
endmodule
